// File: rtl/scanline_scanout.sv
// Line-buffer video scanout: raster counters, ping-pong line buffer reads and a 2-cycle output pipeline.
// Optional 8-bar test pattern is compiled in with `define SCANOUT_TESTPAT_EN.
module scanline_scanout #(
    parameter int H_PIXELS      = 800,
    parameter int H_FRONT_PORCH = 48,
    parameter int H_SYNC        = 32,
    parameter int H_BACK_PORCH  = 80,
    parameter int V_PIXELS      = 600,
    parameter int V_FRONT_PORCH = 3,
    parameter int V_SYNC        = 4,
    parameter int V_BACK_PORCH  = 11,
    parameter bit HSYNC_POL     = 1'b1,
    parameter bit VSYNC_POL     = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [9:0] vram_even_addr,
    input  logic [7:0] vram_even_q,
    output logic [9:0] vram_odd_addr,
    input  logic [7:0] vram_odd_q,
    input  logic       test_en,
    output logic [7:0] rgb,
    output logic       de,
    output logic       hsync,
    output logic       vsync,
    output logic       line_parity,
    output logic       frame_start
);
    localparam int H_TOTAL = H_PIXELS + H_FRONT_PORCH + H_SYNC + H_BACK_PORCH;
    localparam int V_TOTAL = V_PIXELS + V_FRONT_PORCH + V_SYNC + V_BACK_PORCH;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_PIXELS);
    localparam logic [HW-1:0] H_SS   = HW'(H_PIXELS + H_FRONT_PORCH);
    localparam logic [HW-1:0] H_SE   = HW'(H_PIXELS + H_FRONT_PORCH + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_PIXELS);
    localparam logic [VW-1:0] V_SS   = VW'(V_PIXELS + V_FRONT_PORCH);
    localparam logic [VW-1:0] V_SE   = VW'(V_PIXELS + V_FRONT_PORCH + V_SYNC);

    logic [HW-1:0] counter_h_reg, counter_h_next;
    logic [VW-1:0] counter_v_reg, counter_v_next;
    logic          line_parity_reg, line_parity_next;

    // Stage 1 travels alongside the RAM read; stage 2 is the output register.
    logic          de_d1_reg, hs_d1_reg, vs_d1_reg, rd_even_d1_reg;
    logic [7:0]    rgb_reg, rgb_next;
    logic          de_reg, hsync_reg, vsync_reg;

    logic          h_wrap, v_wrap, active_h, active_v, hs_now, vs_now;
    logic [9:0]    addr_sel;

    assign h_wrap   = (counter_h_reg == H_LAST);
    assign v_wrap   = (counter_v_reg == V_LAST);
    assign active_h = (counter_h_reg < H_ACT);
    assign active_v = (counter_v_reg < V_ACT);
    assign hs_now   = (counter_h_reg >= H_SS && counter_h_reg < H_SE) ? HSYNC_POL : ~HSYNC_POL;
    assign vs_now   = (counter_v_reg >= V_SS && counter_v_reg < V_SE) ? VSYNC_POL : ~VSYNC_POL;
    assign addr_sel = active_h ? 10'(counter_h_reg) : 10'd0;

    // The writer owns the buffer named by line_parity; scanout reads the other one.
    assign vram_even_addr = line_parity_reg  ? addr_sel : 10'd0;
    assign vram_odd_addr  = !line_parity_reg ? addr_sel : 10'd0;

    always_comb begin
        counter_h_next   = counter_h_reg + 1'b1;
        counter_v_next   = counter_v_reg;
        line_parity_next = line_parity_reg;
        if (h_wrap) begin
            counter_h_next = '0;
            if (v_wrap) begin
                counter_v_next   = '0;
                line_parity_next = 1'b1;
            end else begin
                counter_v_next   = counter_v_reg + 1'b1;
                line_parity_next = ~line_parity_reg;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter_h_reg   <= '0;
            counter_v_reg   <= '0;
            line_parity_reg <= 1'b1;
        end else begin
            counter_h_reg   <= counter_h_next;
            counter_v_reg   <= counter_v_next;
            line_parity_reg <= line_parity_next;
        end
    end

`ifdef SCANOUT_TESTPAT_EN
    localparam logic [7:0] PAT_ALL = 8'hFF;
    logic [31:0] bar_idx;
    logic [7:0]  pat_d1_reg;

    assign bar_idx = 32'(counter_h_reg) / 32'd100;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pat_d1_reg <= '0;
        else        pat_d1_reg <= PAT_ALL >> bar_idx;
    end

    always_comb begin
        rgb_next = 8'd0;
        if (de_d1_reg)
            rgb_next = test_en ? pat_d1_reg : (rd_even_d1_reg ? vram_even_q : vram_odd_q);
    end
`else
    logic unused_test_en;
    assign unused_test_en = test_en;

    always_comb begin
        rgb_next = 8'd0;
        if (de_d1_reg)
            rgb_next = rd_even_d1_reg ? vram_even_q : vram_odd_q;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de_d1_reg      <= 1'b0;
            hs_d1_reg      <= ~HSYNC_POL;
            vs_d1_reg      <= ~VSYNC_POL;
            rd_even_d1_reg <= 1'b0;
            rgb_reg        <= 8'd0;
            de_reg         <= 1'b0;
            hsync_reg      <= ~HSYNC_POL;
            vsync_reg      <= ~VSYNC_POL;
        end else begin
            de_d1_reg      <= active_h && active_v;
            hs_d1_reg      <= hs_now;
            vs_d1_reg      <= vs_now;
            rd_even_d1_reg <= line_parity_reg;
            rgb_reg        <= rgb_next;
            de_reg         <= de_d1_reg;
            hsync_reg      <= hs_d1_reg;
            vsync_reg      <= vs_d1_reg;
        end
    end

    assign rgb         = rgb_reg;
    assign de          = de_reg;
    assign hsync       = hsync_reg;
    assign vsync       = vsync_reg;
    assign line_parity = line_parity_reg;
    // Gated so the pulse stays low while reset holds the counters at zero.
    assign frame_start = rst_n && (counter_h_reg == '0) && (counter_v_reg == '0);

endmodule

// File: doc/scanline_scanout.md
SCANLINE_SCANOUT -- requirements
Module: scanline_scanout

Interface
REQ-001 SHALL have parameter H_PIXELS, default 800, active pixels per line.
REQ-002 SHALL have parameters H_FRONT_PORCH, H_SYNC, H_BACK_PORCH, defaults 48 / 32 / 80; H_TOTAL derived = 960.
REQ-003 SHALL have parameter V_PIXELS, default 600, active lines per frame.
REQ-004 SHALL have parameters V_FRONT_PORCH, V_SYNC, V_BACK_PORCH, defaults 3 / 4 / 11; V_TOTAL derived = 618.
REQ-005 SHALL have parameters HSYNC_POL, default 1, and VSYNC_POL, default 0: the asserted level of each sync.
REQ-006 SHALL have ports:
  clk  input  1  pixel clock; the only clock; all state on rising edge.
  rst_n  input  1  asynchronous, active-low reset.
  vram_even_addr  output  10  read address, even line buffer.
  vram_even_q  input  8  even buffer read data, valid 1 cycle after address.
  vram_odd_addr  output  10  read address, odd line buffer.
  vram_odd_q  input  8  odd buffer read data, valid 1 cycle after address.
  test_en  input  1  selects test pattern (see Configuration).
  rgb  output  8  pixel colour.
  de  output  1  data enable, high during active pixels.
  hsync  output  1  horizontal sync.
  vsync  output  1  vertical sync.
  line_parity  output  1  buffer currently being filled by the writer (1 = odd).
  frame_start  output  1  one-cycle pulse, first cycle of line 0.

Function
REQ-007 SHALL keep counter_h 0..H_TOTAL-1 incrementing every cycle, wrapping to 0; counter_v increments on each counter_h wrap, 0..V_TOTAL-1, wrapping to 0.
REQ-008 SHALL toggle line_parity on each counter_h wrap, except when counter_v also wraps, where line_parity SHALL be set to 1.
REQ-009 SHALL read the buffer not being written: even when line_parity=1, odd when line_parity=0.
REQ-010 SHALL drive the selected buffer address = counter_h while counter_h < H_PIXELS, else 0; the unselected address SHALL be 0.
REQ-011 SHALL register the pipeline: counter state at cycle N produces rgb/de/hsync/vsync at cycle N+2 (1 RAM cycle + 1 output register); syncs and de delayed to match.
REQ-012 SHALL assert de when delayed counter_h < H_PIXELS and counter_v < V_PIXELS; rgb SHALL be 0 whenever de=0.
REQ-013 SHALL assert hsync (level HSYNC_POL) for counter_h in [H_PIXELS+H_FRONT_PORCH, H_PIXELS+H_FRONT_PORCH+H_SYNC); else the inverse level.
REQ-014 SHALL assert vsync (level VSYNC_POL) for counter_v in [V_PIXELS+V_FRONT_PORCH, V_PIXELS+V_FRONT_PORCH+V_SYNC), evaluated on the same delayed counters as hsync.
REQ-015 SHALL capture the buffer select used for a line with the address, so a parity change at line wrap never mixes buffers within the 2-cycle pipeline.
REQ-016 SHALL pulse frame_start (undelayed) for exactly the cycle where counter_h=0 and counter_v=0.
REQ-017 SHALL compare counters with widths $clog2(H_TOTAL) / $clog2(V_TOTAL); address truncated to 10 bits (H_PIXELS <= 1024 required).

Reset
REQ-018 SHALL on rst_n low set counter_h=0, counter_v=0, line_parity=1, all pipeline stages cleared, rgb=0, de=0, addresses 0, frame_start=0, hsync=!HSYNC_POL, vsync=!VSYNC_POL.
REQ-019 SHALL, after rst_n deasserts, start at counter_h=0/counter_v=0 with frame_start high the first clock edge; reset mid-line SHALL abort the line with no partial output.

Configuration
REQ-020 SHALL, with SCANOUT_TESTPAT_EN defined and test_en=1, output rgb = 8'hFF >> (counter_h / 100) for active pixels (8 bars), VRAM data ignored, same latency and addressing.
REQ-021 SHALL, without SCANOUT_TESTPAT_EN, ignore test_en and always output VRAM data.

Verification
REQ-022 Reset then run 960*618 cycles -> exactly 1 frame_start pulse per 593280 cycles; 480000 de-high cycles per frame.
REQ-023 Even RAM model q=addr[7:0] on line 0 -> rgb at first de cycle = 0x00, at pixel 799 = 0x1F; vram_odd_addr stays 0.
REQ-024 Line 1 -> odd buffer read, line_parity=1 during line 0 and 0 during line 1, no even data in line 1 output.
REQ-025 Check hsync high for delayed counter_h 848..879, vsync low for counter_v 603..606, both exactly 2 cycles after counters.
REQ-026 SCANOUT_TESTPAT_EN, test_en=1 -> pixel 0 = 0xFF, pixel 150 = 0x7F, pixel 750 = 0x01; test_en=0 -> VRAM data.
REQ-027 Assert rst_n low at counter_h=400 line 5 -> outputs reset values within same cycle; restart at frame_start.
